// File: rtl/alu_pkg.sv
// Shared types for the registered ALU: opcode encoding, divider FSM states,
// and the status-flag payload.
package alu_pkg;

    localparam int unsigned ALU_FUN_W = 4;

    typedef enum logic [ALU_FUN_W-1:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_NAND = 4'h6,
        OP_NOR  = 4'h7,
        OP_XOR  = 4'h8,
        OP_XNOR = 4'h9,
        OP_EQ   = 4'hA,
        OP_GT   = 4'hB,
        OP_LT   = 4'hC,
        OP_SHR  = 4'hD,
        OP_SHL  = 4'hE,
        OP_RSV  = 4'hF
    } alu_op_e;

    typedef enum logic {
        IDLE    = 1'b0,
        DIV_RUN = 1'b1
    } state_e;

    typedef struct packed {
        logic carry;
        logic ovf;
        logic div_zero;
    } alu_flags_t;

endpackage

// File: rtl/alu_divider.sv
// Restoring shift-subtract divider, one quotient bit per clock.
// done/quotient/remainder describe the step being completed this cycle so the
// parent can register the final result on the same edge the last step lands.
module alu_divider
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dsr_q;

    logic [WIDTH:0]   trial;
    logic             fit;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] rem_nxt;

    // One restoring step: shift next dividend bit into the partial remainder
    // and subtract the divisor if it fits (no borrow out of bit WIDTH).
    always_comb begin
        trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};
        fit     = ~trial[WIDTH];
        rem_nxt = fit ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_nxt = {quo_q[WIDTH-2:0], fit};
    end

    assign busy      = (state == DIV_RUN);
    assign done      = (state == DIV_RUN) && (cnt == CNT_W'(WIDTH - 1));
    assign quotient  = quo_nxt;
    assign remainder = rem_nxt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            cnt   <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        quo_q <= dividend;
                        dsr_q <= divisor;
                        rem_q <= '0;
                        cnt   <= '0;
                        state <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    quo_q <= quo_nxt;
                    rem_q <= rem_nxt;
                    cnt   <= cnt + CNT_W'(1);
                    if (done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_seq_param.sv
// Parametrised registered ALU: single-cycle ops registered at the accept edge,
// DIV delegated to a multi-cycle divider with a BUSY/OUT_VALID handshake.
module alu_seq_param
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FUN_W = ALU_FUN_W
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               EN,
    input  logic [FUN_W-1:0]   ALU_FUN,
    output logic [2*WIDTH-1:0] ALU_OUT,
    output logic               OUT_VALID,
    output logic               BUSY,
    output logic               CARRY,
    output logic               ZERO,
    output logic               OVF,
    output logic               DIV_ZERO
);

    localparam int unsigned RES_W = 2 * WIDTH;
    localparam int unsigned MSB   = WIDTH - 1;

    alu_op_e          op;
    logic             accept;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;

    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH-1:0] diff_w;
    logic [WIDTH-1:0] logic_w;
    logic [RES_W-1:0] res_c;
    logic [RES_W-1:0] div_res;
    alu_flags_t       flags_c;

    assign op        = alu_op_e'(ALU_FUN);
    assign accept    = EN && !div_busy;
    // Divide-by-zero never enters the divider; it resolves in one cycle below.
    assign div_start = accept && (op == OP_DIV) && (B != '0);
    assign div_res   = {div_rem, div_quo};
    assign BUSY      = div_busy;

    // Single-cycle result and flags for the presented opcode.
    always_comb begin
        sum_w   = {1'b0, A} + {1'b0, B};
        diff_w  = A - B;
        shl_w   = {A, 1'b0};
        logic_w = '0;
        res_c   = '0;
        flags_c = '0;
        case (op)
            OP_ADD: begin
                res_c         = RES_W'(sum_w);
                flags_c.carry = sum_w[WIDTH];
                flags_c.ovf   = (A[MSB] == B[MSB]) && (sum_w[MSB] != A[MSB]);
            end
            OP_SUB: begin
                res_c         = RES_W'(diff_w);
                flags_c.carry = (A < B);
                flags_c.ovf   = (A[MSB] != B[MSB]) && (diff_w[MSB] != A[MSB]);
            end
            OP_MUL: res_c = RES_W'(A) * RES_W'(B);
            OP_DIV: begin
                res_c            = {A, {WIDTH{1'b1}}};
                flags_c.div_zero = 1'b1;
            end
            OP_AND: begin
                logic_w = A & B;
                res_c   = RES_W'(logic_w);
            end
            OP_OR: begin
                logic_w = A | B;
                res_c   = RES_W'(logic_w);
            end
            OP_NAND: begin
                logic_w = ~(A & B);
                res_c   = RES_W'(logic_w);
            end
            OP_NOR: begin
                logic_w = ~(A | B);
                res_c   = RES_W'(logic_w);
            end
            OP_XOR: begin
                logic_w = A ^ B;
                res_c   = RES_W'(logic_w);
            end
            OP_XNOR: begin
                logic_w = ~(A ^ B);
                res_c   = RES_W'(logic_w);
            end
            OP_EQ: res_c = RES_W'(A == B);
            OP_GT: res_c = RES_W'(A > B);
            OP_LT: res_c = RES_W'(A < B);
            OP_SHR: begin
                logic_w = A >> 1;
                res_c   = RES_W'(logic_w);
            end
            OP_SHL:  res_c = RES_W'(shl_w);
            default: res_c = '0;
        endcase
    end

    alu_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .CLK      (CLK),
        .RST      (RST),
        .start    (div_start),
        .dividend (A),
        .divisor  (B),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    // Result/flag registers; div_done and accept are exclusive since accept needs !busy.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ALU_OUT   <= '0;
            OUT_VALID <= 1'b0;
            CARRY     <= 1'b0;
            ZERO      <= 1'b0;
            OVF       <= 1'b0;
            DIV_ZERO  <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;
            if (div_done) begin
                ALU_OUT   <= div_res;
                OUT_VALID <= 1'b1;
                CARRY     <= 1'b0;
                OVF       <= 1'b0;
                DIV_ZERO  <= 1'b0;
                ZERO      <= (div_res == '0);
            end else if (accept && !div_start) begin
                ALU_OUT   <= res_c;
                OUT_VALID <= 1'b1;
                CARRY     <= flags_c.carry;
                OVF       <= flags_c.ovf;
                DIV_ZERO  <= flags_c.div_zero;
                ZERO      <= (res_c == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param (WIDTH=8): opcode vector table plus
// hand sequences for the divider handshake and reset abort.
module tb_alu_seq_param;

    logic        CLK;
    logic        RST;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT;
    logic        OUT_VALID;
    logic        BUSY;
    logic        CARRY;
    logic        ZERO;
    logic        OVF;
    logic        DIV_ZERO;

    int checks = 0;
    int errors = 0;

    alu_seq_param #(.WIDTH(8), .FUN_W(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .A        (A),
        .B        (B),
        .EN       (EN),
        .ALU_FUN  (ALU_FUN),
        .ALU_OUT  (ALU_OUT),
        .OUT_VALID(OUT_VALID),
        .BUSY     (BUSY),
        .CARRY    (CARRY),
        .ZERO     (ZERO),
        .OVF      (OVF),
        .DIV_ZERO (DIV_ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] out;
        logic        c;
        logic        z;
        logic        v;
        logic        dz;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [15:0] out, input logic valid,
                             input logic busy, input logic c, input logic z,
                             input logic v, input logic dz);
        check({tag, ".ALU_OUT"},   32'(ALU_OUT),   32'(out));
        check({tag, ".OUT_VALID"}, 32'(OUT_VALID), 32'(valid));
        check({tag, ".BUSY"},      32'(BUSY),      32'(busy));
        check({tag, ".CARRY"},     32'(CARRY),     32'(c));
        check({tag, ".ZERO"},      32'(ZERO),      32'(z));
        check({tag, ".OVF"},       32'(OVF),       32'(v));
        check({tag, ".DIV_ZERO"},  32'(DIV_ZERO),  32'(dz));
    endtask

    initial begin
        int vcount;
        logic [15:0] hold;

        vecs[0]  = '{"add_200_100", 4'h0, 8'd200, 8'd100, 16'h012C, 1, 0, 0, 0};
        vecs[1]  = '{"add_ovf",     4'h0, 8'd100, 8'd100, 16'h00C8, 0, 0, 1, 0};
        vecs[2]  = '{"sub_5_7",     4'h1, 8'd5,   8'd7,   16'h00FE, 1, 0, 0, 0};
        vecs[3]  = '{"sub_7_7",     4'h1, 8'd7,   8'd7,   16'h0000, 0, 1, 0, 0};
        vecs[4]  = '{"sub_ovf",     4'h1, 8'h80,  8'h01,  16'h007F, 0, 0, 1, 0};
        vecs[5]  = '{"mul_ff_ff",   4'h2, 8'd255, 8'd255, 16'hFE01, 0, 0, 0, 0};
        vecs[6]  = '{"eq_9_9",      4'hA, 8'd9,   8'd9,   16'h0001, 0, 0, 0, 0};
        vecs[7]  = '{"div_by_0",    4'h3, 8'd42,  8'd0,   16'h2AFF, 0, 0, 0, 1};
        vecs[8]  = '{"and",         4'h4, 8'hF0,  8'h3C,  16'h0030, 0, 0, 0, 0};
        vecs[9]  = '{"or",          4'h5, 8'hF0,  8'h3C,  16'h00FC, 0, 0, 0, 0};
        vecs[10] = '{"nand",        4'h6, 8'hF0,  8'h3C,  16'h00CF, 0, 0, 0, 0};
        vecs[11] = '{"nor",         4'h7, 8'hF0,  8'h3C,  16'h0003, 0, 0, 0, 0};
        vecs[12] = '{"xor",         4'h8, 8'hF0,  8'h3C,  16'h00CC, 0, 0, 0, 0};
        vecs[13] = '{"xnor",        4'h9, 8'hF0,  8'h3C,  16'h0033, 0, 0, 0, 0};
        vecs[14] = '{"gt_3_9",      4'hB, 8'd3,   8'd9,   16'h0000, 0, 1, 0, 0};
        vecs[15] = '{"lt_3_9",      4'hC, 8'd3,   8'd9,   16'h0001, 0, 0, 0, 0};
        vecs[16] = '{"shr_81",      4'hD, 8'h81,  8'h00,  16'h0040, 0, 0, 0, 0};
        vecs[17] = '{"shl_81",      4'hE, 8'h81,  8'h00,  16'h0102, 0, 0, 0, 0};
        vecs[18] = '{"reserved",    4'hF, 8'd5,   8'd3,   16'h0000, 0, 1, 0, 0};
        vecs[19] = '{"add_after",   4'h0, 8'd17,  8'd25,  16'h002A, 0, 0, 0, 0};

        RST = 1'b0; EN = 1'b0; A = '0; B = '0; ALU_FUN = '0;
        #12;
        check_all("reset", 16'h0000, 0, 0, 0, 0, 0, 0);
        RST = 1'b1;
        step();

        // Table: one accepted op, then an idle cycle where the result must hold.
        for (int i = 0; i < NV; i++) begin
            A = vecs[i].a; B = vecs[i].b; ALU_FUN = vecs[i].op; EN = 1'b1;
            step();
            EN = 1'b0;
            check_all(vecs[i].name, vecs[i].out, 1, 0, vecs[i].c, vecs[i].z, vecs[i].v, vecs[i].dz);
            step();
            check({vecs[i].name, ".idle_valid"}, 32'(OUT_VALID), 32'd0);
            check({vecs[i].name, ".idle_hold"},  32'(ALU_OUT),   32'(vecs[i].out));
            check({vecs[i].name, ".idle_busy"},  32'(BUSY),      32'd0);
        end
        hold = vecs[NV-1].out;

        // DIV 100/7 with an ADD pulsed mid-divide, then back-to-back ADD.
        A = 8'd100; B = 8'd7; ALU_FUN = 4'h3; EN = 1'b1;
        step();
        EN = 1'b0;
        check("div.busy_e0",  32'(BUSY),      32'd1);
        check("div.valid_e0", 32'(OUT_VALID), 32'd0);
        for (int i = 1; i < 8; i++) begin
            if (i == 3) begin
                A = 8'd1; B = 8'd1; ALU_FUN = 4'h0; EN = 1'b1;
            end
            step();
            EN = 1'b0;
            check($sformatf("div.busy_e%0d", i),  32'(BUSY),      32'd1);
            check($sformatf("div.valid_e%0d", i), 32'(OUT_VALID), 32'd0);
            check($sformatf("div.hold_e%0d", i),  32'(ALU_OUT),   32'(hold));
        end
        step();
        check_all("div_done", 16'h020E, 1, 0, 0, 0, 0, 0);
        A = 8'd3; B = 8'd4; ALU_FUN = 4'h0; EN = 1'b1;
        step();
        EN = 1'b0;
        check_all("b2b_add", 16'h0007, 1, 0, 0, 0, 0, 0);
        step();
        check("b2b_idle_valid", 32'(OUT_VALID), 32'd0);

        // Reset during a divide: immediate clear, no late OUT_VALID.
        A = 8'd100; B = 8'd7; ALU_FUN = 4'h3; EN = 1'b1;
        step();
        EN = 1'b0;
        step(); step(); step();
        check("abort.busy_before", 32'(BUSY), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        check_all("abort_async", 16'h0000, 0, 0, 0, 0, 0, 0);
        step(); step();
        RST = 1'b1;
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (OUT_VALID) vcount++;
        end
        check("abort.no_valid", 32'(vcount), 32'd0);
        check("abort.busy_after", 32'(BUSY), 32'd0);
        A = 8'd1; B = 8'd1; ALU_FUN = 4'h0; EN = 1'b1;
        step();
        EN = 1'b0;
        check_all("post_reset_add", 16'h0002, 1, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
